regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports, range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 reads as 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_W: packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_en, input, NUM_RD: per-port read enable.
REQ-009 SHALL have port rd_data, output, NUM_RD*DATA_W: packed registered read data.
REQ-010 SHALL have ports we0, we1, input, 1 each: write enables for write ports 0 and 1.
REQ-011 SHALL have ports wa0, wa1, input, ADDR_W each: write addresses.
REQ-012 SHALL have ports wd0, wd1, input, DATA_W each: write data.
REQ-013 SHALL have port clr_req, input, 1: single-cycle pulse that starts a sweep clear.
REQ-014 SHALL have port ready, output, 1: high when the block is idle and accepting writes.
REQ-015 SHALL have port wr_drop, output, 1: one-cycle pulse when any write is discarded during a clear.

Function
REQ-016 SHALL implement read latency of one cycle: rd_data port i updates on the edge after rd_en[i] is sampled high, and holds its value while rd_en[i] is low.
REQ-017 SHALL implement write-first bypass: a read sampled in the same cycle as a write to the same address returns the new data.
REQ-018 SHALL give we1 priority when we0 and we1 target the same address in the same cycle; wd1 is stored and bypassed.
REQ-019 SHALL, when ZERO_REG=1, return 0 for reads of address 0 regardless of writes or bypass, and shall never assert wr_drop for a write to address 0.
REQ-020 SHALL implement FSM states IDLE and CLEAR; IDLE goes to CLEAR on clr_req, and CLEAR goes to IDLE on the cycle after the entry at index 2**ADDR_W-1 is zeroed.
REQ-021 SHALL, in CLEAR, zero one entry per cycle using an ADDR_W-bit sweep counter starting at 0, so a clear lasts 2**ADDR_W cycles.
REQ-022 SHALL drive ready low in CLEAR, and ready shall go low on the cycle after clr_req.
REQ-023 SHALL, in CLEAR, discard all we0/we1 writes and pulse wr_drop for one cycle per cycle in which any write is discarded.
REQ-024 SHALL, in CLEAR, return 0 for enabled reads.
REQ-025 SHALL ignore clr_req while already in CLEAR; the sweep is not restarted.
REQ-026 SHALL, when a write coincides with clr_req in IDLE, accept that write and then clear it by the sweep.

Reset
REQ-027 SHALL, on rst_n low, asynchronously zero all entries and rd_data, set the state to IDLE and the sweep counter to 0, drive ready to 1 and wr_drop to 0.
REQ-028 SHALL, when rst_n asserts mid-clear, abort the sweep immediately; on release the block is in IDLE with all entries at 0.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, CLEAR) and the default width constants in shared package cpu_pkg.
REQ-030 SHALL contain one sub-module, regfile_rdport, instantiated NUM_RD times via generate; each instance contains the bypass mux, the zero-register mux and the output register for one read port.

Verification
REQ-031 SHALL verify: write wa0=3, wd0=0xDEAD_BEEF; next cycle read port 0 addr 3 -> rd_data[0] = 0xDEADBEEF one cycle later.
REQ-032 SHALL verify: same-cycle we0 to addr 5 with 0x11 and we1 to addr 5 with 0x22, while port 1 reads addr 5 -> port 1 returns 0x22, and a later read of addr 5 returns 0x22.
REQ-033 SHALL verify: with ZERO_REG=1, write 0xFFFF_FFFF to addr 0, then read addr 0 -> 0 with wr_drop=0.
REQ-034 SHALL verify: fill all 32 entries, pulse clr_req, issue a write at sweep cycle 10 -> ready low for exactly 32 cycles, wr_drop pulses once, and every address reads 0 afterwards.
REQ-035 SHALL verify: assert rst_n low at sweep cycle 7 -> outputs are 0 and ready=1 immediately (without a clock edge), and all entries read 0 after release.
REQ-036 SHALL verify: NUM_RD=4 with four distinct addresses read simultaneously -> each port returns its own entry after one cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Holds the clear-sequencer state encoding used by the top level.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: write-first bypass, zero-register masking
// and the output register that holds its value while the port is disabled.
module regfile_rdport
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              clearing,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] next_data;

    always_comb begin
        byp_data = mem_data;
        if (wr_en0 && (wa0 == rd_addr)) byp_data = wd0;
        // Checked last so port 1 wins a same-address collision.
        if (wr_en1 && (wa1 == rd_addr)) byp_data = wd1;

        next_data = byp_data;
        if (clearing || ((ZERO_REG != 0) && (rd_addr == '0))) next_data = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= next_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports,
// and a one-entry-per-cycle sweep clear that blocks writes while it runs.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd0,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     clr_req,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd [NUM_RD];

    rf_state_t         state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              wr_drop_nxt;
    logic              idle;
    logic              wr_valid0, wr_valid1;
    logic              wr_ok0, wr_ok1;

    assign idle = (state == IDLE);

    // A write to the hard-wired zero entry is neither stored nor counted as dropped.
    assign wr_valid0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr_valid1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign wr_ok0    = wr_valid0 && idle;
    assign wr_ok1    = wr_valid1 && idle;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                if (&clr_cnt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        wr_drop_nxt = !idle && (wr_valid0 || wr_valid1);
    end

    assign ready = idle;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            wr_drop <= wr_drop_nxt;
        end
    end

    // NOTE: the storage array is reset on purpose; reset must leave every entry reading zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (!idle) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr_ok0) mem[wa0] <= wd0;
            if (wr_ok1) mem[wa1] <= wd1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rdport
        assign mem_rd[g] = mem[rd_addr[g*ADDR_W +: ADDR_W]];

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_en[g]),
            .rd_addr  (rd_addr[g*ADDR_W +: ADDR_W]),
            .mem_data (mem_rd[g]),
            .clearing (!idle),
            .wr_en0   (wr_ok0),
            .wa0      (wa0),
            .wd0      (wd0),
            .wr_en1   (wr_ok1),
            .wa1      (wa1),
            .wd1      (wd1),
            .rd_data  (rd_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (4 read ports): directed vector table,
// sweep-clear and mid-clear reset sequences, then random traffic against a model.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [19:0]  rd_addr;
    logic [3:0]   rd_en;
    logic [127:0] rd_data;
    logic         we0, we1;
    logic [4:0]   wa0, wa1;
    logic [31:0]  wd0, wd1;
    logic         clr_req;
    logic         ready;
    logic         wr_drop;

    int n_total = 0;
    int n_pass  = 0;

    regfile_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_RD   (4),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .we0     (we0),
        .we1     (we1),
        .wa0     (wa0),
        .wa1     (wa1),
        .wd0     (wd0),
        .wd1     (wd1),
        .clr_req (clr_req),
        .ready   (ready),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    // Reference model: plain array, cycles-left-in-clear counter, per-port held data.
    logic [31:0] m_mem [32];
    logic [31:0] m_rd [4];
    logic        m_drop;
    int          m_clear_left;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        for (int p = 0; p < 4; p++) m_rd[p] = '0;
        m_drop       = 1'b0;
        m_clear_left = 0;
    endtask

    task automatic model_update();
        bit       clearing;
        bit [4:0] a;
        clearing = (m_clear_left > 0);
        for (int p = 0; p < 4; p++) begin
            if (rd_en[p]) begin
                a = rd_addr[p*5 +: 5];
                if (clearing || a == 0)       m_rd[p] = '0;
                else if (we1 && wa1 == a)     m_rd[p] = wd1;
                else if (we0 && wa0 == a)     m_rd[p] = wd0;
                else                          m_rd[p] = m_mem[a];
            end
        end
        m_drop = clearing && ((we0 && wa0 != 0) || (we1 && wa1 != 0));
        if (clearing) begin
            m_mem[32 - m_clear_left] = '0;
            m_clear_left--;
        end else begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (clr_req) m_clear_left = 32;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_model();
        for (int p = 0; p < 4; p++)
            check($sformatf("rd_data%0d", p), rd_data[p*32 +: 32], m_rd[p]);
        check("ready", {31'b0, ready}, {31'b0, m_clear_left == 0});
        check("wr_drop", {31'b0, wr_drop}, {31'b0, m_drop});
    endtask

    task automatic idle_inputs();
        rd_addr = '0; rd_en = '0;
        we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        clr_req = 0;
    endtask

    // Inputs are driven after a falling edge; the model follows the rising edge;
    // outputs are compared at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic         we0;
        logic [4:0]   wa0;
        logic [31:0]  wd0;
        logic         we1;
        logic [4:0]   wa1;
        logic [31:0]  wd1;
        logic [3:0]   rd_en;
        logic [19:0]  rd_addr;   // {p3, p2, p1, p0}
        logic [127:0] exp_rd;    // {p3, p2, p1, p0}
        logic         exp_drop;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int n_low;
    int n_drop;

    initial begin
        vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 4'b0000, 20'd0,
                     {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},
                     {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 1'b0};
        vecs[2]  = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0},
                     {32'h0, 32'h0, 32'h22, 32'hDEADBEEF}, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0},
                     {32'h0, 32'h22, 32'h22, 32'hDEADBEEF}, 1'b0};
        vecs[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 4'b0000, 20'd0,
                     {32'h0, 32'h22, 32'h22, 32'hDEADBEEF}, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b0001, 20'd0,
                     {32'h0, 32'h22, 32'h22, 32'h0}, 1'b0};
        vecs[6]  = '{1'b1, 5'd7, 32'hABCD0001, 1'b1, 5'd9, 32'h99, 4'b1000, {5'd7, 5'd0, 5'd0, 5'd0},
                     {32'hABCD0001, 32'h22, 32'h22, 32'h0}, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 4'b1000, 20'd0,
                     {32'h0, 32'h22, 32'h22, 32'h0}, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 4'b1111, {5'd9, 5'd7, 5'd5, 5'd3},
                     {32'h99, 32'hABCD0001, 32'h22, 32'hDEADBEEF}, 1'b0};
        vecs[9]  = '{1'b1, 5'd3, 32'h1234, 1'b1, 5'd5, 32'h5678, 4'b0000, 20'd0,
                     {32'h99, 32'hABCD0001, 32'h22, 32'hDEADBEEF}, 1'b0};
        vecs[10] = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},
                     {32'h99, 32'hABCD0001, 32'h22, 32'hBBBB}, 1'b0};

        // Reset state, checked while reset is still asserted.
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int p = 0; p < 4; p++) check($sformatf("reset_rd%0d", p), rd_data[p*32 +: 32], 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h1);
        check("reset_wr_drop", {31'b0, wr_drop}, 32'h0);
        rst_n = 1'b1;

        // Directed vectors: latency, bypass, write-port priority, zero register, 4-port read.
        for (int i = 0; i < NV; i++) begin
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr; clr_req = 1'b0;
            step();
            for (int p = 0; p < 4; p++)
                check($sformatf("vec%0d_rd%0d", i, p), rd_data[p*32 +: 32], vecs[i].exp_rd[p*32 +: 32]);
            check($sformatf("vec%0d_ready", i), {31'b0, ready}, 32'h1);
            check($sformatf("vec%0d_wr_drop", i), {31'b0, wr_drop}, {31'b0, vecs[i].exp_drop});
        end

        // Fill every entry, then sweep-clear with a coincident write, a stray clr_req and a dropped write.
        for (int a = 0; a < 32; a++) begin
            idle_inputs();
            we0 = 1'b1; wa0 = 5'(a); wd0 = $urandom | 32'h1;
            step();
            check_model();
        end
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9999_0009; clr_req = 1'b1;
        step();
        n_low = 0; n_drop = 0;
        for (int k = 0; k < 40; k++) begin
            if (!ready) n_low++;
            if (wr_drop) n_drop++;
            idle_inputs();
            if (k == 3) clr_req = 1'b1;
            if (k == 10) begin we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hCAFE; end
            step();
            check_model();
        end
        check("clear_ready_low_cycles", 32'(n_low), 32'd32);
        check("clear_wr_drop_pulses", 32'(n_drop), 32'd1);
        for (int b = 0; b < 8; b++) begin
            idle_inputs();
            rd_en = 4'hF;
            rd_addr = {5'(b*4+3), 5'(b*4+2), 5'(b*4+1), 5'(b*4)};
            step();
            for (int p = 0; p < 4; p++)
                check($sformatf("after_clear_addr%0d", b*4+p), rd_data[p*32 +: 32], 32'h0);
        end

        // Reset in the middle of a sweep.
        for (int a = 1; a < 32; a++) begin
            idle_inputs();
            we0 = 1'b1; wa0 = 5'(a); wd0 = 32'h0101_0101 * 32'(a) + 32'h1;
            step();
        end
        idle_inputs();
        rd_en = 4'hF; rd_addr = {5'd31, 5'd20, 5'd10, 5'd1};
        step();
        check_model();
        idle_inputs();
        clr_req = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            idle_inputs();
            if (k == 6) begin we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h4444; end
            step();
            check_model();
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int p = 0; p < 4; p++) check($sformatf("midreset_rd%0d", p), rd_data[p*32 +: 32], 32'h0);
        check("midreset_ready", {31'b0, ready}, 32'h1);
        check("midreset_wr_drop", {31'b0, wr_drop}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 8; b++) begin
            idle_inputs();
            rd_en = 4'hF;
            rd_addr = {5'(b*4+3), 5'(b*4+2), 5'(b*4+1), 5'(b*4)};
            step();
            for (int p = 0; p < 4; p++)
                check($sformatf("after_reset_addr%0d", b*4+p), rd_data[p*32 +: 32], 32'h0);
        end

        // Random traffic: addresses kept small to force collisions and bypass hits.
        for (int c = 0; c < 600; c++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
            wd0 = $urandom; wd1 = $urandom;
            rd_en = 4'($urandom);
            for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = 5'($urandom_range(0, 9));
            clr_req = ($urandom_range(0, 59) == 0);
            step();
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
